// File: rtl/field_pack_stage.sv
// Two-beat assembler: field0 then field1 into a registered packed struct.
// Optional FIELD_PACK_ASSERT_EN elaborates consistency assertions.
module field_pack_stage #(
    parameter int FIELD0_WIDTH = 4,
    parameter int FIELD1_WIDTH = 4,
    parameter int IN_WIDTH     = 4,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 clear,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [IN_WIDTH-1:0]                  in_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [FIELD0_WIDTH+FIELD1_WIDTH-1:0] out_struct,
    output logic [FIELD0_WIDTH-1:0]              out_field0,
    output logic [FIELD1_WIDTH-1:0]              out_field1,
    output logic [CNT_WIDTH-1:0]                 out_count
);

    localparam int SW = FIELD0_WIDTH + FIELD1_WIDTH;

    typedef struct packed {
        logic [FIELD0_WIDTH-1:0] field0;
        logic [FIELD1_WIDTH-1:0] field1;
    } pack_t;

    typedef enum logic [1:0] {
        IDLE,
        HAVE_F0,
        FULL
    } state_t;

    generate
        if (IN_WIDTH < FIELD0_WIDTH || IN_WIDTH < FIELD1_WIDTH) begin : g_width_err
            $error("field_pack_stage: IN_WIDTH narrower than a field");
        end
    endgenerate

    state_t                  state;
    state_t                  state_nxt;
    pack_t                   pack_q;
    pack_t                   pack_d;
    logic [FIELD0_WIDTH-1:0] stage_q;
    logic [FIELD0_WIDTH-1:0] stage_d;
    logic [CNT_WIDTH-1:0]    count_q;
    logic [CNT_WIDTH-1:0]    count_d;
    logic                    unused_bits;

    // Beat bits above a field width are intentionally dropped.
    assign unused_bits = ^in_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pack_q  <= '0;
            stage_q <= '0;
            count_q <= '0;
        end else begin
            state   <= state_nxt;
            pack_q  <= pack_d;
            stage_q <= stage_d;
            count_q <= count_d;
        end
    end

    // field0 lands in stage_q first, so the visible struct never tears.
    always_comb begin
        state_nxt = state;
        pack_d    = pack_q;
        stage_d   = stage_q;
        count_d   = count_q;
        in_ready  = 1'b0;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            in_ready = (state != FULL) || out_ready;
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        stage_d   = in_data[FIELD0_WIDTH-1:0];
                        state_nxt = HAVE_F0;
                    end
                end
                HAVE_F0: begin
                    if (in_valid) begin
                        pack_d.field0 = stage_q;
                        pack_d.field1 = in_data[FIELD1_WIDTH-1:0];
                        state_nxt     = FULL;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        count_d = count_q + 1'b1;
                        if (in_valid) begin
                            stage_d   = in_data[FIELD0_WIDTH-1:0];
                            state_nxt = HAVE_F0;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign out_valid  = (state == FULL);
    assign out_struct = pack_q;
    assign out_field0 = pack_q.field0;
    assign out_field1 = pack_q.field1;
    assign out_count  = count_q;

`ifdef FIELD_PACK_ASSERT_EN
    always_comb begin
        assert (pack_q.field0 === out_struct[SW-1:FIELD1_WIDTH]);
        assert (pack_q.field1 === out_struct[FIELD1_WIDTH-1:0]);
        assert (out_field0 === pack_q.field0);
        assert (!(out_valid && state != FULL));
    end
`else
`endif

endmodule

// File: tb/tb_field_pack_stage.sv
// Scoreboard bench: default 4/4/4 instance plus a 3/5/8 instance in lockstep.
module tb_field_pack_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] in_data8;
    logic [3:0] in_data4;

    logic       a_in_ready, a_out_valid;
    logic [7:0] a_struct;
    logic [3:0] a_f0, a_f1;
    logic [7:0] a_count;

    logic       b_in_ready, b_out_valid;
    logic [7:0] b_struct;
    logic [2:0] b_f0;
    logic [4:0] b_f1;
    logic [7:0] b_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] s0;
        logic [7:0] s1;
        logic [7:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: beats since last flush, held struct, handoff count.
    bit         have_f0;
    logic [7:0] f0_beat;
    bit         held;
    logic [7:0] last0, last1;
    int         cnt;
    bit         rdy_exp;

    assign in_data4 = in_data8[3:0];

    always #5 clk = ~clk;

    field_pack_stage u_a (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data4),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_struct(a_struct), .out_field0(a_f0), .out_field1(a_f1),
        .out_count(a_count)
    );

    field_pack_stage #(
        .FIELD0_WIDTH(3), .FIELD1_WIDTH(5), .IN_WIDTH(8), .CNT_WIDTH(8)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data8),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_struct(b_struct), .out_field0(b_f0), .out_field1(b_f1),
        .out_count(b_count)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        have_f0 = 0;
        f0_beat = '0;
        held    = 0;
        last0   = '0;
        last1   = '0;
        cnt     = 0;
        exp_q.delete();
    endtask

    task automatic check_outputs();
        rdy_exp = !clear && (!held || out_ready);
        chk("a_in_ready", {31'b0, a_in_ready}, {31'b0, rdy_exp});
        chk("b_in_ready", {31'b0, b_in_ready}, {31'b0, rdy_exp});
        chk("a_out_valid", {31'b0, a_out_valid}, {31'b0, held});
        chk("b_out_valid", {31'b0, b_out_valid}, {31'b0, held});
        chk("a_struct", {24'b0, a_struct}, {24'b0, last0});
        chk("b_struct", {24'b0, b_struct}, {24'b0, last1});
        chk("a_field0", {28'b0, a_f0}, {28'b0, last0[7:4]});
        chk("a_field1", {28'b0, a_f1}, {28'b0, last0[3:0]});
        chk("b_field0", {29'b0, b_f0}, {29'b0, last1[7:5]});
        chk("b_field1", {27'b0, b_f1}, {27'b0, last1[4:0]});
        chk("a_count", {24'b0, a_count}, cnt);
        chk("b_count", {24'b0, b_count}, cnt);
    endtask

    // Advance the model across the coming rising edge.
    task automatic model_step();
        bit acc;
        acc = in_valid && rdy_exp;
        if (clear) begin
            if (held) void'(exp_q.pop_back());
            held    = 0;
            have_f0 = 0;
        end else begin
            if (held && out_ready) begin
                held = 0;
                cnt  = (cnt + 1) % 256;
            end
            if (acc) begin
                if (!have_f0) begin
                    f0_beat = in_data8;
                    have_f0 = 1;
                end else begin
                    last0   = {f0_beat[3:0], in_data8[3:0]};
                    last1   = {f0_beat[2:0], in_data8[4:0]};
                    have_f0 = 0;
                    held    = 1;
                    exp_q.push_back('{last0, last1, 8'(cnt)});
                end
            end
        end
    endtask

    task automatic cycle(input bit v, input logic [7:0] d,
                         input bit r, input bit c);
        @(negedge clk);
        in_valid  = v;
        in_data8  = d;
        out_ready = r;
        clear     = c;
        #1;
        check_outputs();
        model_step();
    endtask

    // Monitor: pops the scoreboard on every output handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (rst_n && a_out_valid && out_ready && !clear) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 32'd0, 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_a_struct", {24'b0, a_struct}, {24'b0, e.s0});
                    chk("sb_b_struct", {24'b0, b_struct}, {24'b0, e.s1});
                    chk("sb_a_count", {24'b0, a_count}, {24'b0, e.cnt});
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data8  = '0;
        model_reset();
        #2;
        chk("rst_valid", {31'b0, a_out_valid}, 32'd0);
        chk("rst_struct", {24'b0, a_struct}, 32'd0);
        chk("rst_count", {24'b0, a_count}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", {31'b0, a_in_ready}, 32'd1);

        // Basic pack
        cycle(1, 8'h0A, 1, 0);
        cycle(1, 8'h05, 1, 0);
        cycle(0, 8'h00, 1, 0);
        chk("basic_struct", {24'b0, a_struct}, 32'hA5);
        chk("basic_valid", {31'b0, a_out_valid}, 32'd1);
        cycle(0, 8'h00, 1, 0);
        chk("basic_count", {24'b0, a_count}, 32'd1);

        // Backpressure
        cycle(1, 8'h03, 0, 0);
        cycle(1, 8'h0C, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cycle(1, 8'h05, 0, 0);
            chk("bp_hold", {24'b0, a_struct}, 32'h3C);
            chk("bp_rdy", {31'b0, a_in_ready}, 32'd0);
        end
        cycle(0, 8'h00, 1, 0);
        cycle(0, 8'h00, 1, 0);
        chk("bp_count", {24'b0, a_count}, 32'd2);

        // Back-to-back
        cycle(1, 8'h01, 1, 0);
        cycle(1, 8'h02, 1, 0);
        cycle(1, 8'h03, 1, 0);
        chk("b2b_s0", {24'b0, a_struct}, 32'h12);
        chk("b2b_rdy", {31'b0, a_in_ready}, 32'd1);
        cycle(1, 8'h04, 1, 0);
        cycle(0, 8'h00, 1, 0);
        chk("b2b_s1", {24'b0, a_struct}, 32'h34);

        // Clear discards partial field0
        cycle(1, 8'h07, 1, 0);
        cycle(0, 8'h00, 1, 1);
        cycle(1, 8'h09, 1, 0);
        cycle(1, 8'h01, 0, 0);
        cycle(0, 8'h00, 0, 0);
        chk("clr_struct", {24'b0, a_struct}, 32'h91);
        chk("clr_count", {24'b0, a_count}, 32'd4);
        cycle(0, 8'h00, 1, 0);

        // Upper beat bits ignored on the narrow-field instance
        cycle(1, 8'hFF, 1, 0);
        cycle(1, 8'hE2, 1, 0);
        cycle(0, 8'h00, 0, 0);
        chk("w_b_struct", {24'b0, b_struct}, 32'hE2);
        chk("w_b_f0", {29'b0, b_f0}, 32'h7);
        chk("w_b_f1", {27'b0, b_f1}, 32'h02);
        chk("w_a_struct", {24'b0, a_struct}, 32'hF2);
        cycle(0, 8'h00, 1, 0);

        // Async reset mid-HAVE_F0
        cycle(1, 8'h06, 1, 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("mrst_valid", {31'b0, a_out_valid}, 32'd0);
        chk("mrst_struct", {24'b0, a_struct}, 32'd0);
        chk("mrst_count", {24'b0, a_count}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mrst_in_ready", {31'b0, a_in_ready}, 32'd1);

        // Random traffic, long enough for the counter to wrap
        for (int i = 0; i < 1600; i++) begin
            cycle($urandom_range(0, 99) < 85, 8'($urandom),
                  $urandom_range(0, 99) < 80,
                  $urandom_range(0, 99) < 2);
        end

        for (int i = 0; i < 4; i++) cycle(0, 8'h00, 1, 0);
        chk("drain", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
